// File: rtl/rs_excitation_driver.sv
// rs_excitation_driver
// Turns a requested next-state bit into a single legal R/S excitation pulse
// for an RS flip-flop on the same clock, waits SETTLE_CYCLES idle cycles,
// then checks the flop's q/qbar feedback against the request.
// Sequence per request: IDLE -> DRIVE -> SETTLE (skipped when SETTLE_CYCLES==0)
// -> CHECK -> IDLE, i.e. one request every SETTLE_CYCLES+3 cycles.
// Optional build macro: RS_IDLE_MONITOR_EN -- when defined, the driver also
// watches the feedback while idle and pulses err (done low) whenever the flop
// disagrees with q_model or shows q==qbar.
module rs_excitation_driver #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic tgt_valid,
   input  logic tgt_bit,
   output logic tgt_ready,
   output logic R,
   output logic S,
   input  logic q_fb,
   input  logic qbar_fb,
   output logic busy,
   output logic done,
   output logic err,
   output logic q_model
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   // Counter start value; only meaningful when there is a settle phase at all.
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   state_t           state;
   logic [CNT_W-1:0] settle_cnt;
   logic             tgt_q;
   logic             mismatch;

   // Feedback must show exactly the requested value on q and its complement on qbar.
   assign mismatch = (q_fb != tgt_q) || (qbar_fb != ~tgt_q);

   // Request sequencer; every output is registered here so R/S are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         tgt_q      <= 1'b0;
         R          <= 1'b0;
         S          <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         q_model    <= 1'b0;
         busy       <= 1'b0;
         tgt_ready  <= 1'b1;
      end else begin
         // done/err are single-cycle pulses unless a state below re-asserts them.
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
`ifdef RS_IDLE_MONITOR_EN
               err <= (q_fb != q_model) || (qbar_fb == q_fb);
`endif
               if (tgt_valid) begin
                  tgt_q     <= tgt_bit;
                  // Pulse only the input that moves the flop; equal request holds.
                  S         <= tgt_bit & ~q_model;
                  R         <= ~tgt_bit & q_model;
                  busy      <= 1'b1;
                  tgt_ready <= 1'b0;
                  state     <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               R <= 1'b0;
               S <= 1'b0;
               if (SETTLE_CYCLES > 0) begin
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ST_SETTLE;
               end else begin
                  state <= ST_CHECK;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CHECK: begin
               done      <= 1'b1;
               err       <= mismatch;
               // q_model tracks the command; recovery after err is the caller's job.
               q_model   <= tgt_q;
               busy      <= 1'b0;
               tgt_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
